mode_ctrl: RTL

//   Front-end user controller. It produces the mode[2:0] and song_num[1:0] codes

---
 rtl/mode_ctrl.sv | 118 +++++++++++
 1 files changed

// File: rtl/mode_ctrl.sv
// Front-end user controller: synchronises and debounces four push-buttons and runs
// the menu FSM that produces the mode / song selection codes for the signal selector.
module mode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 2_000_000,
  parameter int CNT_W           = 21,
  parameter int NUM_SONGS       = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_back,
  output logic [2:0] mode,
  output logic [1:0] song_num,
  output logic       song_restart
);

  localparam int              NB        = 4;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [1:0]      LAST_SONG = 2'(NUM_SONGS - 1);

  // Button bit order: 0 mode, 1 up, 2 down, 3 back.
  logic [NB-1:0]    raw;
  logic [NB-1:0]    sync1;
  logic [NB-1:0]    sync2;
  logic [NB-1:0]    level;
  logic [NB-1:0]    level_q;
  logic [NB-1:0]    press;
  logic [CNT_W-1:0] cnt [NB];

  assign raw = {btn_back, btn_down, btn_up, btn_mode};

  // The debounced level only follows the synced input once it has differed
  // for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= '0;
      sync2   <= '0;
      level   <= '0;
      level_q <= '0;
      for (int i = 0; i < NB; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1   <= raw;
      sync2   <= sync1;
      level_q <= level;
      for (int i = 0; i < NB; i++) begin
        if (sync2[i] != level[i]) begin
          if (cnt[i] == CNT_MAX) begin
            level[i] <= sync2[i];
            cnt[i]   <= '0;
          end else begin
            cnt[i] <= cnt[i] + CNT_W'(1);
          end
        end else begin
          cnt[i] <= '0;
        end
      end
    end
  end

  assign press = level & ~level_q;

  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    FREE  = 3'b001,
    AUTO  = 3'b011,
    LEARN = 3'b111
  } state_t;

  state_t     state;
  logic [1:0] song_inc;
  logic [1:0] song_dec;
  logic       song_sel;

  assign mode     = state;
  assign song_inc = (song_num == LAST_SONG) ? 2'd0 : song_num + 2'd1;
  assign song_dec = (song_num == 2'd0) ? LAST_SONG : song_num - 2'd1;
  assign song_sel = (state == AUTO) || (state == LEARN);

  // Priority back > mode > up/down; up and down together cancel each other.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      song_num     <= 2'd0;
      song_restart <= 1'b0;
    end else begin
      song_restart <= 1'b0;
      if (press[3]) begin
        state <= IDLE;
      end else if (press[0]) begin
        case (state)
          IDLE:    state <= FREE;
          FREE: begin
            state        <= AUTO;
            song_restart <= 1'b1;
          end
          AUTO: begin
            state        <= LEARN;
            song_restart <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end else if (song_sel && (press[1] ^ press[2])) begin
        if (press[1]) begin
          song_num     <= song_inc;
          song_restart <= (song_inc != song_num);
        end else begin
          song_num     <= song_dec;
          song_restart <= (song_dec != song_num);
        end
      end
    end
  end

endmodule
